// File: rtl/blk_line_buffer_ctrl_if.sv
// blk_line_buffer_ctrl_if: pixel-in / block-out handshake bundle for the line buffer controller
interface blk_line_buffer_ctrl_if #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
);
  localparam int CW = (IMG_W / BLK > 1) ? $clog2(IMG_W / BLK) : 1;
  localparam int RW = (IMG_H / BLK > 1) ? $clog2(IMG_H / BLK) : 1;
  logic [PIX_W-1:0]         i_pix_data;
  logic                     i_pix_valid;
  logic                     o_pix_ready;
  logic [BLK*BLK*PIX_W-1:0] o_blk_data;
  logic                     o_blk_valid;
  logic                     i_blk_ready;
  logic [CW-1:0]            o_blk_col;
  logic [RW-1:0]            o_blk_row;
  logic                     o_frame_done;
  modport slave (
    input  i_pix_data, i_pix_valid, i_blk_ready,
    output o_pix_ready, o_blk_data, o_blk_valid, o_blk_col, o_blk_row, o_frame_done
  );
  modport master (
    output i_pix_data, i_pix_valid, i_blk_ready,
    input  o_pix_ready, o_blk_data, o_blk_valid, o_blk_col, o_blk_row, o_frame_done
  );
endinterface

// File: rtl/blk_line_buffer_ctrl.sv
// blk_line_buffer_ctrl: ping-pong BLK-line raster buffer emitting BLKxBLK blocks; LBC_LEVEL_SHIFT_EN enables signed level shift
module blk_line_buffer_ctrl #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input logic i_clk,
  input logic i_rst,
  blk_line_buffer_ctrl_if.slave bus
);
  localparam int NBC = IMG_W / BLK;
  localparam int NBR = IMG_H / BLK;
  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LW  = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int CW  = (NBC > 1) ? $clog2(NBC) : 1;
  localparam int RW  = (NBR > 1) ? $clog2(NBR) : 1;
  localparam int BW  = BLK * BLK * PIX_W;
`ifdef LBC_LEVEL_SHIFT_EN
  localparam logic [PIX_W-1:0] LS_MASK = {1'b1, {(PIX_W-1){1'b0}}};
`else
  localparam logic [PIX_W-1:0] LS_MASK = '0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;
  state_t           state_q, state_d;
  logic [PIX_W-1:0] mem_q [2][BLK][IMG_W];
  logic [XW-1:0]    x_q, x_d;
  logic [LW-1:0]    line_q, line_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             valid_q, valid_d;
  logic [BW-1:0]    data_q, data_d;
  logic [BW-1:0]    blk_rd;
  logic             pix_acc, line_end, strip_end, blk_acc, last_col, last_row;

  assign bus.o_pix_ready  = !full_q[wr_bank_q];
  assign pix_acc          = bus.i_pix_valid && bus.o_pix_ready;
  assign line_end         = pix_acc && (x_q == XW'(IMG_W - 1));
  assign strip_end        = line_end && (line_q == LW'(BLK - 1));
  assign blk_acc          = (state_q == SHOW) && bus.i_blk_ready;
  assign last_col         = col_q == CW'(NBC - 1);
  assign last_row         = row_q == RW'(NBR - 1);
  assign bus.o_blk_data   = data_q;
  assign bus.o_blk_valid  = valid_q;
  assign bus.o_blk_col    = col_q;
  assign bus.o_blk_row    = row_q;
  assign bus.o_frame_done = blk_acc && last_col && last_row;

  // pixel storage; contents survive reset, only the flags and counters are cleared
  always_ff @(posedge i_clk) begin
    if (pix_acc) mem_q[wr_bank_q][line_q][x_q] <= bus.i_pix_data;
  end

  // gather the block at the current column of the read bank, with optional level shift
  always_comb begin
    blk_rd = '0;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        blk_rd[(r*BLK + c)*PIX_W +: PIX_W] = mem_q[rd_bank_q][LW'(r)][XW'(int'(col_q)*BLK + c)] ^ LS_MASK;
  end

  // write-side raster counters and bank flags; a set and a clear never hit the same bank
  always_comb begin
    x_d       = !pix_acc ? x_q : line_end ? '0 : x_q + XW'(1);
    line_d    = !line_end ? line_q : strip_end ? '0 : line_q + LW'(1);
    wr_bank_d = wr_bank_q ^ strip_end;
    full_d    = full_q;
    if (strip_end) full_d[wr_bank_q] = 1'b1;
    if (blk_acc && last_col) full_d[rd_bank_q] = 1'b0;
  end

  // read FSM: wait for a full bank, load a block, present it until accepted
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    rd_bank_d = rd_bank_q;
    valid_d   = valid_q;
    data_d    = data_q;
    case (state_q)
      IDLE: state_d = full_q[rd_bank_q] ? LOAD : IDLE;
      LOAD: begin
        data_d  = blk_rd;
        valid_d = 1'b1;
        state_d = SHOW;
      end
      SHOW: if (bus.i_blk_ready) begin
        valid_d   = 1'b0;
        col_d     = last_col ? '0 : col_q + CW'(1);
        row_d     = !last_col ? row_q : last_row ? '0 : row_q + RW'(1);
        rd_bank_d = rd_bank_q ^ last_col;
        state_d   = last_col ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      line_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      line_q    <= line_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      col_q     <= col_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end
endmodule

// File: tb/tb_blk_line_buffer_ctrl.sv
// tb_blk_line_buffer_ctrl: scoreboard bench for a 16x16 image in 8x8 blocks
module tb_blk_line_buffer_ctrl;
  localparam int PIX_W = 8;
  localparam int BLK   = 8;
  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int BW    = BLK * BLK * PIX_W;
`ifdef LBC_LEVEL_SHIFT_EN
  localparam logic [7:0] MASK = 8'h80;
`else
  localparam logic [7:0] MASK = 8'h00;
`endif
  typedef struct {
    logic [BW-1:0] data;
    int            col;
    int            row;
    logic          fd;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;
  exp_t q[$];
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data  = '0;

  always #5 i_clk = ~i_clk;

  blk_line_buffer_ctrl_if #(.PIX_W(PIX_W), .BLK(BLK), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();
  blk_line_buffer_ctrl #(.PIX_W(PIX_W), .BLK(BLK), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pix(input int kind, input int y, input int x);
    case (kind)
      0:       return 8'(y * 16 + x);
      1:       return 8'hFF;
      2:       return 8'h00;
      default: return 8'(y * 16 + x) ^ 8'h5A;
    endcase
  endfunction

  task automatic push_frame(input int kind);
    exp_t e;
    for (int br = 0; br < IMG_H / BLK; br++)
      for (int bc = 0; bc < IMG_W / BLK; bc++) begin
        e.data = '0;
        for (int r = 0; r < BLK; r++)
          for (int c = 0; c < BLK; c++)
            e.data[(r*BLK + c)*PIX_W +: PIX_W] = pix(kind, br*BLK + r, bc*BLK + c) ^ MASK;
        e.col = bc;
        e.row = br;
        e.fd  = (br == IMG_H / BLK - 1) && (bc == IMG_W / BLK - 1);
        q.push_back(e);
      end
  endtask

  task automatic put(input logic [7:0] d, input bit gap);
    int t = 0;
    if (gap && $urandom_range(1) == 1) begin
      @(negedge i_clk);
      bus.i_pix_valid = 1'b0;
    end
    @(negedge i_clk);
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = d;
    while (!bus.o_pix_ready && t < 3000) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 3000) begin
      tests++;
      fails++;
      $display("FAIL pix_accept timeout actual=ready_low required=accept");
    end
    @(posedge i_clk);
  endtask

  task automatic send_frame(input int kind, input bit gap);
    push_frame(kind);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) put(pix(kind, y, x), gap);
    @(negedge i_clk);
    bus.i_pix_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain timeout actual=%0d pending required=0", q.size());
    end
    repeat (4) @(negedge i_clk);
  endtask

  task automatic check_reset();
    check("rst_pix_ready", bus.o_pix_ready, 1);
    check("rst_blk_valid", bus.o_blk_valid, 0);
    check("rst_blk_data", bus.o_blk_data, 0);
    check("rst_blk_col", bus.o_blk_col, 0);
    check("rst_blk_row", bus.o_blk_row, 0);
    check("rst_frame_done", bus.o_frame_done, 0);
  endtask

  initial begin
    bus.i_blk_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      bus.i_blk_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : !bus.i_blk_ready;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", bus.o_blk_valid, 1);
        check("hold_data", bus.o_blk_data, prev_data);
      end
      if (bus.o_blk_valid && bus.i_blk_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_block actual=col%0d_row%0d required=none", bus.o_blk_col, bus.o_blk_row);
        end else begin
          check("blk_data", bus.o_blk_data, q[0].data);
          check("blk_col", bus.o_blk_col, q[0].col);
          check("blk_row", bus.o_blk_row, q[0].row);
          check("frame_done", bus.o_frame_done, q[0].fd);
          void'(q.pop_front());
        end
      end else if (bus.o_frame_done) check("frame_done_idle", bus.o_frame_done, 0);
      prev_stall <= bus.o_blk_valid && !bus.i_blk_ready;
      prev_data  <= bus.o_blk_data;
    end
  end

  initial begin
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data  = '0;
    repeat (3) @(negedge i_clk);
    check_reset();
    i_rst = 1'b0;
    mode = 0;
    send_frame(0, 0);
    drain();
    mode = 2;
    send_frame(3, 0);
    drain();
    mode = 0;
    send_frame(0, 1);
    drain();
    mode = 1;
    send_frame(0, 0);
    check("pix_ready_drop", bus.o_pix_ready, 0);
    repeat (10) @(negedge i_clk);
    check("pix_ready_held", bus.o_pix_ready, 0);
    fork
      send_frame(3, 0);
      begin
        repeat (20) @(negedge i_clk);
        mode = 0;
      end
    join
    drain();
    send_frame(1, 0);
    drain();
    send_frame(2, 0);
    drain();
    for (int i = 0; i < 70; i++) put(pix(0, i / IMG_W, i % IMG_W), 0);
    @(negedge i_clk);
    bus.i_pix_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset();
    i_rst = 1'b0;
    send_frame(0, 0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/blk_line_buffer_ctrl.md
Name: blk_line_buffer_ctrl

Overview:
- Parametrised successor to the fixed 16-line image controller.
- Accepts a raster pixel stream over a valid/ready handshake and stores it in two ping-pong banks of BLK line buffers.
- Emits complete BLK x BLK pixel blocks, left to right, over a valid/ready handshake to the downstream DCT.
- Filling one bank overlaps with draining the other; backpressure is applied only when both banks are full.

Parameters:
- PIX_W, 8, bits per pixel
- BLK, 8, block edge in pixels; also the number of lines per bank
- IMG_W, 256, image width in pixels; must be a multiple of BLK
- IMG_H, 256, image height in lines; must be a multiple of BLK

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_pix_data  in  PIX_W  raster-order input pixel
- i_pix_valid  in  1  input pixel valid
- o_pix_ready  out  1  controller can accept a pixel
- o_blk_data  out  BLK*BLK*PIX_W  block; row r at [r*BLK*PIX_W +: BLK*PIX_W], column c within a row at [c*PIX_W +: PIX_W]
- o_blk_valid  out  1  block valid
- i_blk_ready  in  1  downstream accepts block
- o_blk_col  out  clog2(IMG_W/BLK)  block column index of the presented block
- o_blk_row  out  clog2(IMG_H/BLK)  block row (strip) index of the presented block
- o_frame_done  out  1  one-cycle pulse on acceptance of the last block of a frame

Behaviour:
- Reset clears all state: o_pix_ready=1, o_blk_valid=0, o_blk_data=0, o_blk_col=0, o_blk_row=0, o_frame_done=0, both banks empty, wr_bank=0, rd_bank=0. Buffer contents need not be cleared.
- Write side:
  - A pixel is accepted when i_pix_valid && o_pix_ready.
  - The write x counter runs 0..IMG_W-1; the line counter runs 0..BLK-1 within the current bank.
  - On the accepted pixel at x=IMG_W-1, line=BLK-1: set full[wr_bank], toggle wr_bank, zero both counters.
  - o_pix_ready = !full[wr_bank], combinational from registered flags.
- Read FSM:
  - IDLE: when full[rd_bank] -> LOAD.
  - LOAD: register the block at column blk_col from bank rd_bank into o_blk_data; set o_blk_valid=1 -> SHOW.
  - SHOW: hold o_blk_data, o_blk_col and o_blk_row stable until i_blk_ready.
    - On handshake, if blk_col < IMG_W/BLK-1: blk_col+1, o_blk_valid=0 -> LOAD.
    - Otherwise: clear full[rd_bank], toggle rd_bank, blk_col=0, increment blk_row with wrap at IMG_H/BLK-1, o_blk_valid=0 -> IDLE.
- Latency:
  - First block: o_blk_valid rises 2 cycles after the accept of the last pixel of a strip (flag set, then LOAD).
  - Consecutive blocks in a strip: at most one per 2 cycles.
- Simultaneous set of full[wr_bank] and clear of full[rd_bank] in the same cycle: both take effect. Both can never target the same bank.
- Frame: o_frame_done pulses in the handshake cycle of block (IMG_H/BLK-1, IMG_W/BLK-1); the next frame starts seamlessly.
- Input data held while o_pix_ready=0 is not consumed. o_blk_valid, once high, never drops without a handshake.
- Reset mid-frame discards all buffered data; the next accepted pixel is treated as frame pixel (0,0).

Optional Feature:
- Macro: LBC_LEVEL_SHIFT_EN.
- Defined: each pixel in o_blk_data is output as two's-complement (pixel - 2^(PIX_W-1)), implemented as an MSB inversion, for direct DCT input. Example: 0x00 -> 0x80 (-128), 0xFF -> 0x7F.
- Undefined: pixels pass through unsigned and unchanged.

Test Plan:
- IMG_W=16, IMG_H=16, BLK=8, pixel value = (y*16+x) mod 256, ready always 1 -> 4 blocks in order (0,0),(0,1),(1,0),(1,1). Block (0,1) row 0 = 0x08..0x0F; block (1,0) row 0 = 0x80..0x87. o_frame_done pulses once, on the 4th block.
- Hold i_blk_ready=0 after strip 0 -> strip 1 fills bank 1. o_pix_ready drops to 0 on the cycle after pixel (x=15, y=15) is accepted, and stays 0. Release ready -> stream resumes, no pixel lost or duplicated.
- Toggle i_blk_ready every other cycle -> o_blk_data stable while o_blk_valid && !i_blk_ready; each block seen exactly once.
- Insert random i_pix_valid gaps (50%) -> output blocks identical to the gap-free run.
- Assert i_rst for 1 cycle after 70 pixels -> all outputs at reset values; a fresh frame afterwards yields correct block (0,0) = 0x00..0x07 in row 0.
- With LBC_LEVEL_SHIFT_EN, all-0xFF frame -> every o_blk_data pixel = 0x7F; all-0x00 frame -> every pixel = 0x80.
